// File: rtl/cache_ctrl_wb.sv
// Direct-mapped, write-back, write-allocate cache controller with one-word lines.
// Includes a flush sequencer that writes every dirty line back to memory.
module cache_ctrl_wb #(
  parameter int unsigned ADR_LENGTH  = 32,
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned LINES       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_cpu_i,
  input  logic                   we_cpu_i,
  input  logic [ADR_LENGTH-1:0]  adr_cpu_i,
  input  logic [DATA_LENGTH-1:0] dat_cpu_i,
  output logic [DATA_LENGTH-1:0] dat_cpu_o,
  output logic                   ack_cpu_o,
  output logic                   err_cpu_o,
  output logic                   cyc_m2s,
  output logic                   we_m2s,
  output logic [ADR_LENGTH-1:0]  adr_m2s,
  output logic [DATA_LENGTH-1:0] dat_m2s,
  input  logic [DATA_LENGTH-1:0] dat_mem_i,
  input  logic                   ack_mem_i,
  input  logic                   err_mem_i,
  input  logic                   flush_i,
  output logic                   flush_done_o
);

  localparam int unsigned OFF_W = $clog2(DATA_LENGTH / 8);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADR_LENGTH - IDX_W - OFF_W;
  localparam logic [ADR_LENGTH-1:0] LINE_MASK = ~ADR_LENGTH'((DATA_LENGTH / 8) - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(LINES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    REFILL,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]       valid;
  logic [LINES-1:0]       dirty;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [DATA_LENGTH-1:0] data_mem [LINES];

  logic [IDX_W-1:0] scan_idx, scan_idx_nxt;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic [IDX_W-1:0] wb_idx;
  logic [ADR_LENGTH-1:0] victim_adr;
  logic hit;
  logic flush_last;
  logic fill;
  logic wr_hit;
  logic wb_done;

  assign cpu_idx    = adr_cpu_i[OFF_W +: IDX_W];
  assign cpu_tag    = adr_cpu_i[ADR_LENGTH-1 -: TAG_W];
  assign hit        = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign flush_last = (scan_idx == LAST_IDX);

  // The victim line is the CPU's index on a miss, or the scan pointer while flushing.
  assign wb_idx     = (state == FLUSH_WB) ? scan_idx : cpu_idx;
  assign victim_adr = ADR_LENGTH'({tag_mem[wb_idx], wb_idx}) << OFF_W;

  // State, scan pointer and line status bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      scan_idx <= '0;
      valid    <= '0;
      dirty    <= '0;
    end else begin
      state    <= state_nxt;
      scan_idx <= scan_idx_nxt;
      if (fill) begin
        valid[cpu_idx] <= 1'b1;
        dirty[cpu_idx] <= we_cpu_i;
      end
      if (wr_hit) begin
        dirty[cpu_idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty[wb_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[cpu_idx]  <= cpu_tag;
      data_mem[cpu_idx] <= we_cpu_i ? dat_cpu_i : dat_mem_i;
    end else if (wr_hit) begin
      data_mem[cpu_idx] <= dat_cpu_i;
    end
  end

  always_comb begin
    state_nxt    = state;
    scan_idx_nxt = scan_idx;
    dat_cpu_o    = '0;
    ack_cpu_o    = 1'b0;
    err_cpu_o    = 1'b0;
    cyc_m2s      = 1'b0;
    we_m2s       = 1'b0;
    adr_m2s      = '0;
    dat_m2s      = '0;
    flush_done_o = 1'b0;
    fill         = 1'b0;
    wr_hit       = 1'b0;
    wb_done      = 1'b0;

    case (state)
      IDLE: begin
        if (flush_i) begin
          state_nxt    = FLUSH_SCAN;
          scan_idx_nxt = '0;
        end else if (req_cpu_i) begin
          state_nxt = COMPARE;
        end
      end

      COMPARE: begin
        if (hit) begin
          ack_cpu_o = 1'b1;
          state_nxt = IDLE;
          if (we_cpu_i) begin
            wr_hit = 1'b1;
          end else begin
            dat_cpu_o = data_mem[cpu_idx];
          end
        end else if (valid[cpu_idx] && dirty[cpu_idx]) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = REFILL;
        end
      end

      WRITEBACK: begin
        cyc_m2s = 1'b1;
        we_m2s  = 1'b1;
        adr_m2s = victim_adr;
        dat_m2s = data_mem[cpu_idx];
        if (err_mem_i) begin
          err_cpu_o = 1'b1;
          state_nxt = IDLE;
        end else if (ack_mem_i) begin
          wb_done   = 1'b1;
          state_nxt = REFILL;
        end
      end

      REFILL: begin
        cyc_m2s = 1'b1;
        adr_m2s = adr_cpu_i & LINE_MASK;
        if (err_mem_i) begin
          err_cpu_o = 1'b1;
          state_nxt = IDLE;
        end else if (ack_mem_i) begin
          fill      = 1'b1;
          ack_cpu_o = 1'b1;
          state_nxt = IDLE;
          if (!we_cpu_i) begin
            dat_cpu_o = dat_mem_i;
          end
        end
      end

      FLUSH_SCAN: begin
        if (valid[scan_idx] && dirty[scan_idx]) begin
          state_nxt = FLUSH_WB;
        end else if (flush_last) begin
          flush_done_o = 1'b1;
          state_nxt    = IDLE;
        end else begin
          scan_idx_nxt = scan_idx + IDX_W'(1);
        end
      end

      FLUSH_WB: begin
        cyc_m2s = 1'b1;
        we_m2s  = 1'b1;
        adr_m2s = victim_adr;
        dat_m2s = data_mem[scan_idx];
        if (ack_mem_i || err_mem_i) begin
          wb_done = ack_mem_i && !err_mem_i;
          if (flush_last) begin
            flush_done_o = 1'b1;
            state_nxt    = IDLE;
          end else begin
            scan_idx_nxt = scan_idx + IDX_W'(1);
            state_nxt    = FLUSH_SCAN;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
